// File: rtl/idu_stage.sv
// Instruction-decode pipeline stage: registers the fetched instruction, PC,
// operands and decoded control bundle between IFU and EXU with a
// valid/ready handshake. An optional one-entry skid buffer breaks the
// combinational out_ready -> in_ready path. Two saturating performance
// counters track EXU stalls and empty-slot cycles.
module idu_stage #(
   parameter int unsigned       XLEN     = 64,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       CTRL_W   = 24,
   parameter logic [CTRL_W-1:0] CTRL_RST = 24'h000002,
   parameter bit                SKID     = 1'b1,
   parameter int unsigned       CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        rs1,
   output logic [4:0]        rs2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_rs1_data,
   output logic [XLEN-1:0]   out_rs2_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   input  logic              perf_clr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam int unsigned     PW      = INST_W + 3 * XLEN + CTRL_W;
   localparam logic [PW-1:0]   PAY_RST = {{(PW - CTRL_W){1'b0}}, CTRL_RST};

   logic [PW-1:0] in_pay;
   logic [PW-1:0] out_pay;
   logic          in_fire;
   logic          out_fire;

   // Register-file read addresses go straight out so operands arrive with the instruction.
   assign rs1 = in_inst[19:15];
   assign rs2 = in_inst[24:20];

   // The whole payload travels as one vector so it can only ever be captured as a unit.
   assign in_pay = {in_inst, in_pc, in_rs1_data, in_rs2_data, in_ctrl};
   assign {out_inst, out_pc, out_rs1_data, out_rs2_data, out_ctrl} = out_pay;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   generate
      if (SKID) begin : g_skid
         logic          skid_valid;
         logic [PW-1:0] skid_pay;

         // in_ready depends only on held state (plus flush/reset), never on out_ready.
         assign in_ready = !skid_valid & !flush & !rst;

         // Output slot refills from the skid entry first to preserve arrival order;
         // a new arrival parks in the skid entry only when the output slot is stalled.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid  <= 1'b0;
               out_pay    <= PAY_RST;
               skid_valid <= 1'b0;
               skid_pay   <= '0;
            end else if (flush) begin
               out_valid              <= 1'b0;
               skid_valid             <= 1'b0;
               out_pay[CTRL_W-1:0]    <= CTRL_RST;
            end else if (!out_valid || out_fire) begin
               if (skid_valid) begin
                  out_pay    <= skid_pay;
                  out_valid  <= 1'b1;
                  skid_valid <= 1'b0;
               end else if (in_fire) begin
                  out_pay   <= in_pay;
                  out_valid <= 1'b1;
               end else begin
                  out_valid <= 1'b0;
               end
            end else if (in_fire) begin
               skid_pay   <= in_pay;
               skid_valid <= 1'b1;
            end
         end
      end else begin : g_reg
         // Plain register slice: accept whenever the slot is empty or draining this cycle.
         assign in_ready = (!out_valid | out_ready) & !flush & !rst;

         // Single output register; a load in the same cycle as out_fire replaces the entry.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid <= 1'b0;
               out_pay   <= PAY_RST;
            end else if (flush) begin
               out_valid           <= 1'b0;
               out_pay[CTRL_W-1:0] <= CTRL_RST;
            end else if (in_fire) begin
               out_pay   <= in_pay;
               out_valid <= 1'b1;
            end else if (out_fire) begin
               out_valid <= 1'b0;
            end
         end
      end
   endgenerate

   // Saturating stall/bubble counters; perf_clr wins over the increment, flush is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (perf_clr) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (!out_valid && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/idu_stage.md
IDU_STAGE -- requirements
Module: idu_stage

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 64, register/PC width.
- INST_W, 32, instruction width.
- CTRL_W, 24, width of the decoded control bundle.
- CTRL_RST, 24'h000002, reset/flush value of out_ctrl.
- SKID, 1, enables the one-entry skid buffer (0 = plain register slice).
- CNT_W, 32, performance counter width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); clock and reset come first:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, IFU offers an instruction.
- in_ready, out, 1, stage accepts the offered instruction.
- in_inst, in, INST_W, fetched instruction.
- in_pc, in, XLEN, PC of the fetched instruction.
- in_rs1_data, in, XLEN, register-file read data for rs1.
- in_rs2_data, in, XLEN, register-file read data for rs2.
- in_ctrl, in, CTRL_W, decoded control bundle from the external combinational decoder.
- rs1, out, 5, equals in_inst[19:15].
- rs2, out, 5, equals in_inst[24:20].
- out_valid, out, 1, EXU-side entry is valid.
- out_ready, in, 1, EXU accepts the entry.
- out_inst, out, INST_W, registered instruction.
- out_pc, out, XLEN, registered PC.
- out_rs1_data, out, XLEN, registered rs1 operand.
- out_rs2_data, out, XLEN, registered rs2 operand.
- out_ctrl, out, CTRL_W, registered control bundle.
- flush, in, 1, synchronous kill of all held entries.
- perf_clr, in, 1, synchronous clear of both counters.
- stall_cnt, out, CNT_W, cycles with out_valid=1 and out_ready=0.
- bubble_cnt, out, CNT_W, cycles with out_valid=0.

Function
REQ-003 An input transfer (in_fire) SHALL occur exactly when in_valid=1 and in_ready=1.
REQ-004 An output transfer (out_fire) SHALL occur exactly when out_valid=1 and out_ready=1.
REQ-005 rs1 and rs2 SHALL be purely combinational from in_inst, valid regardless of in_valid.
REQ-006 Payload SHALL be {inst, pc, rs1_data, rs2_data, ctrl}; it SHALL be captured as a unit and never partially updated.
REQ-007 With SKID=0, in_ready SHALL be (!out_valid | out_ready) & !flush, and in_fire SHALL load the output register on the next edge with latency 1 cycle.
REQ-008 With SKID=1, in_ready SHALL be !skid_valid & !flush, driven only from registered state.
REQ-009 With SKID=1 and in_fire:
- If the output register is empty or out_fire occurs, the payload SHALL go to the output register.
- Otherwise the payload SHALL go to the skid entry and skid_valid SHALL be set.
REQ-010 With SKID=1, on out_fire with skid_valid=1, the skid entry SHALL move to the output register and skid_valid SHALL clear; out_valid SHALL stay 1.
REQ-011 On out_fire with no replacement entry, out_valid SHALL clear on the next edge.
REQ-012 Entries SHALL leave in arrival order; none SHALL be dropped or duplicated except by flush or reset.
REQ-013 While out_valid=1 and out_ready=0, all out_* payload outputs SHALL hold stable.
REQ-014 flush=1 SHALL have priority over every other event:
- Next edge: out_valid=0, skid_valid=0, out_ctrl=CTRL_RST.
- Any input offered in that cycle is not accepted.
- An out_fire in that cycle still counts as consumed by the EXU.
REQ-015 stall_cnt SHALL increment by 1 each cycle with out_valid=1 & out_ready=0, and saturate at 2^CNT_W-1.
REQ-016 bubble_cnt SHALL increment by 1 each cycle with out_valid=0, and saturate at 2^CNT_W-1.
REQ-017 perf_clr=1 SHALL zero both counters on the next edge, overriding that cycle's increment.
REQ-018 flush SHALL NOT affect the counters.

Reset
REQ-019 rst=1 SHALL asynchronously force:
- out_valid=0, skid_valid=0.
- out_inst, out_pc, out_rs1_data, out_rs2_data = 0.
- out_ctrl=CTRL_RST.
- stall_cnt=0, bubble_cnt=0.
REQ-020 While rst=1, in_ready SHALL read 0.
REQ-021 Reset asserted mid-transfer SHALL discard all held entries; the first cycle after deassertion SHALL have out_valid=0 and in_ready=1.

Verification
REQ-022 Streaming, SKID=1: in_valid=1 and out_ready=1 continuously with pc 0x80000000, +4 ... -> out_pc sequence 0x80000000, 0x80000004, ... one per cycle after 1 cycle latency; stall_cnt stays 0.
REQ-023 Backpressure: out_ready=0 for 3 cycles while 2 instructions arrive -> first held stable, second in skid, in_ready=0, stall_cnt=3; on release both emerge in order with no loss.
REQ-024 Flush with skid full: flush=1 -> next cycle out_valid=0, skid empty, out_ctrl=24'h000002, in_ready=1 after flush drops.
REQ-025 SKID=0 build: out_ready=0 with an entry held -> in_ready=0; out_ready=1 with in_valid=1 -> back-to-back transfer in the same cycle.
REQ-026 Async reset mid-stall: assert rst between edges -> outputs immediately 0 / CTRL_RST and counters 0, without waiting for an edge.
REQ-027 Counter saturation with CNT_W=4: hold the stall for 20 cycles -> stall_cnt=15; perf_clr=1 -> 0 next edge.
